// File: rtl/div_n_bit_pkg.sv
// Shared divider definitions: FSM encoding, default width and fixed latency.
// The hazard/stall unit uses DivLatency to know how long the divider holds the Hi/Lo pair.
package div_n_bit_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } div_state_e;

    localparam int unsigned DivWidth   = 32;
    // Cycles from the cycle carrying an accepted start to the done cycle.
    localparam int unsigned DivLatency = DivWidth + 2;

endpackage

// File: rtl/div_n_bit_if.sv
// Request/response bundle between the execute stage and the iterative divider.
interface div_n_bit_if
    import div_n_bit_pkg::*;
#(
    parameter int unsigned N = DivWidth
);
    logic         start;
    logic [N-1:0] X;
    logic [N-1:0] Y;
    logic         Signed;
    logic         busy;
    logic         done;
    logic [N-1:0] OutHi;
    logic [N-1:0] OutLo;
    logic         div_zero;

    modport master (
        output start, X, Y, Signed,
        input  busy, done, OutHi, OutLo, div_zero
    );

    modport slave (
        input  start, X, Y, Signed,
        output busy, done, OutHi, OutLo, div_zero
    );
endinterface

// File: rtl/div_n_bit_step.sv
// One restoring-division step: shift the next dividend bit into R, subtract D when it fits.
module div_n_bit_step #(
    parameter int unsigned N = 32
) (
    input  logic [N:0]   r_i,
    input  logic [N-1:0] d_i,
    input  logic         bit_i,
    output logic [N:0]   r_next_o,
    output logic         q_bit_o
);
    logic [N:0] r_shift;
    logic [N:0] d_ext;

    always_comb begin
        r_shift = {r_i[N-1:0], bit_i};
        d_ext   = {1'b0, d_i};
        // A set top bit in R would already exceed any divisor once shifted.
        q_bit_o  = r_i[N] | (r_shift >= d_ext);
        r_next_o = q_bit_o ? (r_shift - d_ext) : r_shift;
    end
endmodule

// File: rtl/div_n_bit.sv
// Iterative N-bit restoring divider, signed or unsigned; OutHi = remainder, OutLo = quotient.
module div_n_bit
    import div_n_bit_pkg::*;
#(
    parameter int unsigned N = DivWidth
) (
    input  logic         clk,
    input  logic         rst,
    div_n_bit_if.slave   bus
);
    localparam int unsigned CntW = $clog2(N);

    div_state_e    state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N:0]    rem_q, rem_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [N-1:0]  raw_x_q, raw_x_d;
    logic          q_neg_q, q_neg_d;
    logic          r_neg_q, r_neg_d;
    logic          zero_q, zero_d;
    logic [N-1:0]  out_hi_q, out_hi_d;
    logic [N-1:0]  out_lo_q, out_lo_d;
    logic          div_zero_q, div_zero_d;

    logic [N-1:0]  x_mag, y_mag;
    logic [N:0]    step_r;
    logic          step_q;

    div_n_bit_step #(
        .N (N)
    ) u_step (
        .r_i      (rem_q),
        .d_i      (dvs_q),
        .bit_i    (quo_q[N-1]),
        .r_next_o (step_r),
        .q_bit_o  (step_q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StCalc;
            StCalc:  if (cnt_q == '0) state_d = StFix;
            StFix:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs.
    always_comb begin
        bus.busy     = (state_q == StCalc) || (state_q == StFix);
        bus.done     = (state_q == StDone);
        bus.OutHi    = out_hi_q;
        bus.OutLo    = out_lo_q;
        bus.div_zero = div_zero_q;
    end

    // Datapath: capture, restoring iteration and sign fix-up.
    always_comb begin
        x_mag      = (bus.Signed && bus.X[N-1]) ? (~bus.X + 1'b1) : bus.X;
        y_mag      = (bus.Signed && bus.Y[N-1]) ? (~bus.Y + 1'b1) : bus.Y;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        raw_x_d    = raw_x_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        zero_d     = zero_q;
        out_hi_d   = out_hi_q;
        out_lo_d   = out_lo_q;
        div_zero_d = div_zero_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    quo_d   = x_mag;
                    dvs_d   = y_mag;
                    rem_d   = '0;
                    raw_x_d = bus.X;
                    q_neg_d = bus.Signed & (bus.X[N-1] ^ bus.Y[N-1]);
                    r_neg_d = bus.Signed & bus.X[N-1];
                    zero_d  = (bus.Y == '0);
                    cnt_d   = CntW'(N - 1);
                end
            end
            StCalc: begin
                rem_d = step_r;
                quo_d = {quo_q[N-2:0], step_q};
                cnt_d = cnt_q - 1'b1;
            end
            StFix: begin
                div_zero_d = zero_q;
                if (zero_q) begin
                    out_lo_d = '1;
                    out_hi_d = raw_x_q;
                end else begin
                    out_lo_d = q_neg_q ? (~quo_q + 1'b1) : quo_q;
                    out_hi_d = r_neg_q ? (~rem_q[N-1:0] + 1'b1) : rem_q[N-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            raw_x_q    <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            zero_q     <= 1'b0;
            out_hi_q   <= '0;
            out_lo_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            raw_x_q    <= raw_x_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            zero_q     <= zero_d;
            out_hi_q   <= out_hi_d;
            out_lo_q   <= out_lo_d;
            div_zero_q <= div_zero_d;
        end
    end
endmodule

// File: tb/tb_div_n_bit.sv
// Scoreboard bench for div_n_bit: directed divisions, handshake corner cases and reset abort.
module tb_div_n_bit;
    localparam int unsigned N = 32;

    typedef struct {
        logic [N-1:0] lo;
        logic [N-1:0] hi;
        logic         dz;
        int unsigned  due;
        string        tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sb[$];
    int unsigned cyc    = 0;
    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    div_n_bit_if #(.N(N)) bus ();

    div_n_bit #(
        .N (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: done at cycle %0d, expected no done", cyc);
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_lo"}, bus.OutLo, e.lo);
                chk({e.tag, "_hi"}, bus.OutHi, e.hi);
                chk({e.tag, "_dz"}, N'(bus.div_zero), N'(e.dz));
                chk({e.tag, "_latency"}, N'(cyc), N'(e.due));
            end
        end
    end

    task automatic issue(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic s, input logic push,
                         input logic [N-1:0] lo, input logic [N-1:0] hi, input logic dz);
        exp_t e;
        @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.X      = x;
        bus.Y      = y;
        bus.Signed = s;
        if (push) begin
            e.lo  = lo;
            e.hi  = hi;
            e.dz  = dz;
            e.due = cyc + 34;
            e.tag = tag;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_timeout: done not seen in 100 cycles, expected done", tag);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        @(negedge clk);
        chk({tag, "_busy"}, N'(bus.busy), '0);
        chk({tag, "_done"}, N'(bus.done), '0);
        chk({tag, "_hi"}, bus.OutHi, '0);
        chk({tag, "_lo"}, bus.OutLo, '0);
        chk({tag, "_dz"}, N'(bus.div_zero), '0);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.X      = '0;
        bus.Y      = '0;
        bus.Signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_idle_zero("reset");

        issue("u100_7", 32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 32'd2, 1'b0);
        wait_done("u100_7");
        issue("sm7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        wait_done("sm7_2");
        // Issued straight after done: must be accepted in IDLE.
        issue("s7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
        wait_done("s7_m2");
        issue("sm100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 1'b1, 32'd14, 32'hFFFF_FFFE, 1'b0);
        wait_done("sm100_m7");
        issue("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
        wait_done("s_ovf");
        issue("u_big", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0, 32'h8000_0000, 1'b0);
        wait_done("u_big");
        issue("u_dz", 32'd5, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1);
        wait_done("u_dz");
        issue("s_dz", 32'hFFFF_FFFD, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
        wait_done("s_dz");

        // A start pulse with new operands mid-operation must not disturb the result.
        issue("hs_first", 32'd1000, 32'd10, 1'b0, 1'b1, 32'd100, 32'd0, 1'b0);
        repeat (8) @(posedge clk);
        issue("hs_ignored", 32'd50, 32'd7, 1'b0, 1'b0, '0, '0, 1'b0);
        wait_done("hs_first");

        // Start presented during the done cycle is dropped.
        bus.start = 1'b1;
        bus.X     = 32'd1;
        bus.Y     = 32'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("done_cycle_start_busy", N'(bus.busy), '0);

        // Reset in the middle of CALC aborts with no done.
        issue("abort", 32'd100, 32'd7, 1'b0, 1'b0, '0, '0, 1'b0);
        repeat (18) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_idle_zero("abort");
        repeat (45) @(posedge clk);
        issue("u9_3", 32'd9, 32'd3, 1'b0, 1'b1, 32'd3, 32'd0, 1'b0);
        wait_done("u9_3");

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", N'(sb.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
